multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control unit for the RISC core: a sequencing FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB, driving the datapath control word one phase at a time. It replaces the single-cycle opcode decoder. It adds a ready/ack memory handshake with a bounded wait, illegal-opcode trapping and a sticky trap state. It sits between the instruction register / memory interfaces and the datapath muxes, register file and ALU.

## Interface
- OPCODE_W, 6, opcode width taken from IR
- ALU_OP_W, 3, ALU operation code width
- WAIT_MAX, 15, max cycles a memory request may wait for ack before trap (≥1)
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  OPCODE_W  opcode field of IR; sampled only in DECODE
- imem_ack  in  1  instruction memory has returned data this cycle
- dmem_ack  in  1  data memory read data valid / write accepted this cycle
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load IR from instruction memory
- pc_write  out  1  update PC (PC+4 or branch target per `branch`)
- dmem_req  out  1  data memory request
- mem_read, mem_write  out  1 each  data access type, valid with dmem_req
- reg_write  out  2  00 none, 10 ALU→rd, 11 mem→rd, 01 link PC+4→ra
- mem_to_reg  out  1  writeback mux: 1 = memory data
- alu_op  out  ALU_OP_W  ALU function
- alu_src  out  1  1 = immediate operand
- branch  out  2  00 none, 01 / 10 conditional kinds, 11 jump-and-link
- trap  out  1  sticky: illegal opcode or memory timeout
- state_o  out  3  current state, for debug

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset → FETCH.
- Opcode decode (latched in DECODE into opcode register):
  - 0/1/2: ALU imm-form (alu_src 1, alu_op 001/010/011), path EXEC→WB, reg_write 10.
  - 3/4: conditional branch (alu_src 1, alu_op 000, branch 01/10), path EXEC→FETCH.
  - 5: load (alu_op 100, alu_src 0), path EXEC→MEM→WB, reg_write 11, mem_to_reg 1.
  - 6: store (alu_op 101), path EXEC→MEM→FETCH.
  - 7/8: ALU reg-form (alu_src 0, alu_op 110/111), EXEC→WB, reg_write 10.
  - 9: jump-and-link (alu_src 1, branch 11), EXEC→FETCH, reg_write 01 in EXEC.
  - Any other opcode: DECODE→TRAP.
- Outputs are a function of state and latched opcode only; no combinational path opcode→outputs.
- All strobes are 0 outside the states listed here. In TRAP, all strobes are 0 and trap=1; TRAP exits only on rst.

## Timing
- Reset: every output 0, state_o = FETCH encoding, wait counter 0, opcode register 0.
- FETCH: imem_req=1 each cycle until imem_ack sampled high. ir_write=1 combinationally in that ack cycle; next state DECODE.
- DECODE: one cycle, no strobes.
- EXEC: alu_op/alu_src valid.
  - Branch/JAL: branch and pc_write=1 for this single cycle (JAL also reg_write=01), then FETCH.
  - Otherwise go to MEM or WB.
- MEM: dmem_req plus mem_read (load) or mem_write (store) held until dmem_ack.
  - Load ack → WB.
  - Store ack → pc_write=1 in that cycle, then FETCH.
- WB: reg_write (+mem_to_reg) and pc_write=1 for one cycle, then FETCH.
- Wait counter: clears on entering FETCH/MEM and counts cycles without ack. When it reaches WAIT_MAX with no ack, next state is TRAP. Ack on the WAIT_MAX-th cycle wins.
- Zero-wait latency (ack in first request cycle): branch/JAL 3, ALU 4, store 4, load 5 cycles.
- Ack while not requesting: ignored.
- rst mid-instruction: immediate return to FETCH; no pending strobe survives.

## Structure
- Package `risc_ctrl_pkg`: opcode localparams (OP_ADDI … OP_JAL), state enum, reg_write and branch encodings, default control-word constant.
- Sub-module `ctrl_decode`: combinational opcode → {alu_op, alu_src, reg_write, mem_to_reg, branch, class, illegal}. The FSM wraps it and gates fields by state.

## Test plan
- Opcode 0, both acks immediate → ir_write at cycle 1, alu_op=001, alu_src=1 in EXEC; reg_write=10 and pc_write in cycle 4; back in FETCH.
- Opcode 5, dmem_ack after 3 cycles → mem_read+dmem_req held 3 cycles; WB gives reg_write=11, mem_to_reg=1; total 7 cycles.
- Opcode 9 → EXEC cycle shows branch=11, reg_write=01, pc_write=1; next cycle FETCH.
- Opcode 6'b111111 → TRAP after DECODE, trap=1 stays high 100 cycles, all strobes 0; rst clears it.
- WAIT_MAX=15, imem_ack never → imem_req high 15 cycles, then TRAP. Ack on cycle 15 → DECODE instead.
- rst asserted during MEM of a store → outputs 0 asynchronously, no mem_write after release, FETCH restarts.

Source files
------------

// File: rtl/risc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// control-field encodings and the idle control word.
package risc_ctrl_pkg;

   localparam int unsigned OPCODE_W_DEF = 6;
   localparam int unsigned ALU_OP_W_DEF = 3;

   localparam int unsigned OP_ADDI = 0;
   localparam int unsigned OP_ANDI = 1;
   localparam int unsigned OP_ORI  = 2;
   localparam int unsigned OP_BEQ  = 3;
   localparam int unsigned OP_BNE  = 4;
   localparam int unsigned OP_LW   = 5;
   localparam int unsigned OP_SW   = 6;
   localparam int unsigned OP_ADD  = 7;
   localparam int unsigned OP_SUB  = 8;
   localparam int unsigned OP_JAL  = 9;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_BRANCH,
      CLS_LOAD,
      CLS_STORE,
      CLS_JAL
   } op_class_e;

   typedef enum logic [1:0] {
      RW_NONE = 2'b00,
      RW_LINK = 2'b01,
      RW_ALU  = 2'b10,
      RW_MEM  = 2'b11
   } reg_write_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_EQ   = 2'b01,
      BR_NE   = 2'b10,
      BR_JAL  = 2'b11
   } branch_e;

   // Width-independent part of the control word driven by the FSM.
   typedef struct packed {
      logic       imem_req;
      logic       ir_write;
      logic       pc_write;
      logic       dmem_req;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] reg_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic [1:0] branch;
      logic       trap;
   } strobe_t;

   localparam strobe_t CTRL_IDLE = '0;

   // Opcodes are contiguous from 0, so legality is a single compare.
   function automatic logic opcode_legal(input logic [31:0] op);
      return op <= 32'(OP_JAL);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps an opcode to its datapath fields,
// instruction class and an illegal flag. The FSM gates these by state.
module ctrl_decode
   import risc_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int ALU_OP_W = 3
) (
   input  logic [OPCODE_W-1:0] opcode,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                alu_src,
   output logic [1:0]          reg_write,
   output logic                mem_to_reg,
   output logic [1:0]          branch,
   output op_class_e           op_class,
   output logic                illegal
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      alu_op     = '0;
      alu_src    = 1'b0;
      reg_write  = RW_NONE;
      mem_to_reg = 1'b0;
      branch     = BR_NONE;
      op_class   = CLS_ALU;
      illegal    = !opcode_legal(32'(opcode));
      case (opcode)
         OPCODE_W'(OP_ADDI): begin
            alu_op    = ALU_OP_W'(3'b001);
            alu_src   = 1'b1;
            reg_write = RW_ALU;
         end
         OPCODE_W'(OP_ANDI): begin
            alu_op    = ALU_OP_W'(3'b010);
            alu_src   = 1'b1;
            reg_write = RW_ALU;
         end
         OPCODE_W'(OP_ORI): begin
            alu_op    = ALU_OP_W'(3'b011);
            alu_src   = 1'b1;
            reg_write = RW_ALU;
         end
         OPCODE_W'(OP_BEQ): begin
            alu_src  = 1'b1;
            branch   = BR_EQ;
            op_class = CLS_BRANCH;
         end
         OPCODE_W'(OP_BNE): begin
            alu_src  = 1'b1;
            branch   = BR_NE;
            op_class = CLS_BRANCH;
         end
         OPCODE_W'(OP_LW): begin
            alu_op     = ALU_OP_W'(3'b100);
            reg_write  = RW_MEM;
            mem_to_reg = 1'b1;
            op_class   = CLS_LOAD;
         end
         OPCODE_W'(OP_SW): begin
            alu_op   = ALU_OP_W'(3'b101);
            op_class = CLS_STORE;
         end
         OPCODE_W'(OP_ADD): begin
            alu_op    = ALU_OP_W'(3'b110);
            reg_write = RW_ALU;
         end
         OPCODE_W'(OP_SUB): begin
            alu_op    = ALU_OP_W'(3'b111);
            reg_write = RW_ALU;
         end
         OPCODE_W'(OP_JAL): begin
            alu_src   = 1'b1;
            reg_write = RW_LINK;
            branch    = BR_JAL;
            op_class  = CLS_JAL;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing FSM: FETCH/DECODE/EXEC/MEM/WB with bounded memory
// handshakes and a sticky TRAP state for illegal opcodes and timeouts.
module multicycle_control
   import risc_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int ALU_OP_W = 3,
   parameter int WAIT_MAX = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                imem_ack,
   input  logic                dmem_ack,
   output logic                imem_req,
   output logic                ir_write,
   output logic                pc_write,
   output logic                dmem_req,
   output logic                mem_read,
   output logic                mem_write,
   output logic [1:0]          reg_write,
   output logic                mem_to_reg,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                alu_src,
   output logic [1:0]          branch,
   output logic                trap,
   output logic [2:0]          state_o
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   state_e              state;
   state_e              state_next;
   logic [OPCODE_W-1:0] op_q;
   logic [CNT_W-1:0]    wait_cnt;
   logic                waiting;
   logic                mem_ack;
   logic                timeout;
   strobe_t             ctrl;

   logic [ALU_OP_W-1:0] dec_alu_op;
   logic                dec_alu_src;
   logic [1:0]          dec_reg_write;
   logic                dec_mem_to_reg;
   logic [1:0]          dec_branch;
   op_class_e           dec_class;
   logic                dec_illegal;

   // Decoding only the latched opcode keeps opcode off every output path.
   ctrl_decode #(
      .OPCODE_W (OPCODE_W),
      .ALU_OP_W (ALU_OP_W)
   ) u_decode (
      .opcode     (op_q),
      .alu_op     (dec_alu_op),
      .alu_src    (dec_alu_src),
      .reg_write  (dec_reg_write),
      .mem_to_reg (dec_mem_to_reg),
      .branch     (dec_branch),
      .op_class   (dec_class),
      .illegal    (dec_illegal)
   );

   assign waiting = (state == FETCH) || (state == MEM);
   assign mem_ack = (state == FETCH) ? imem_ack : dmem_ack;
   assign timeout = waiting && !mem_ack && (wait_cnt == CNT_W'(WAIT_MAX - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst) state <= FETCH;
      else     state <= state_next;
   end

   // Opcode latch and handshake wait counter; the counter is zero outside FETCH/MEM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         wait_cnt <= '0;
      end else begin
         if (state == DECODE) op_q <= opcode;
         if (waiting && !mem_ack) wait_cnt <= wait_cnt + CNT_W'(1);
         else                     wait_cnt <= '0;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         FETCH: begin
            if (imem_ack)     state_next = DECODE;
            else if (timeout) state_next = TRAP;
         end
         DECODE: begin
            if (opcode_legal(32'(opcode))) state_next = EXEC;
            else                           state_next = TRAP;
         end
         EXEC: begin
            if (dec_illegal) state_next = TRAP;
            else begin
               unique case (dec_class)
                  CLS_BRANCH, CLS_JAL:  state_next = FETCH;
                  CLS_LOAD, CLS_STORE:  state_next = MEM;
                  default:              state_next = WB;
               endcase
            end
         end
         MEM: begin
            if (dmem_ack)     state_next = (dec_class == CLS_LOAD) ? WB : FETCH;
            else if (timeout) state_next = TRAP;
         end
         WB:      state_next = FETCH;
         TRAP:    state_next = TRAP;
         default: state_next = TRAP;
      endcase
   end

   // Output logic: reset forces the idle word even though the state register already reads FETCH.
   always_comb begin
      ctrl   = CTRL_IDLE;
      alu_op = '0;
      if (!rst) begin
         unique case (state)
            FETCH: begin
               ctrl.imem_req = 1'b1;
               ctrl.ir_write = imem_ack;
            end
            EXEC: begin
               alu_op       = dec_alu_op;
               ctrl.alu_src = dec_alu_src;
               if (dec_class == CLS_BRANCH || dec_class == CLS_JAL) begin
                  ctrl.branch    = dec_branch;
                  ctrl.reg_write = dec_reg_write;
                  ctrl.pc_write  = 1'b1;
               end
            end
            MEM: begin
               ctrl.dmem_req  = 1'b1;
               ctrl.mem_read  = (dec_class == CLS_LOAD);
               ctrl.mem_write = (dec_class == CLS_STORE);
               ctrl.pc_write  = (dec_class == CLS_STORE) && dmem_ack;
            end
            WB: begin
               ctrl.reg_write  = dec_reg_write;
               ctrl.mem_to_reg = dec_mem_to_reg;
               ctrl.pc_write   = 1'b1;
            end
            TRAP:    ctrl.trap = 1'b1;
            default: ;
         endcase
      end
   end

   assign imem_req   = ctrl.imem_req;
   assign ir_write   = ctrl.ir_write;
   assign pc_write   = ctrl.pc_write;
   assign dmem_req   = ctrl.dmem_req;
   assign mem_read   = ctrl.mem_read;
   assign mem_write  = ctrl.mem_write;
   assign reg_write  = ctrl.reg_write;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign alu_src    = ctrl.alu_src;
   assign branch     = ctrl.branch;
   assign trap       = ctrl.trap;
   assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a cycle-by-cycle vector table for
// every opcode plus hand-written timeout, trap and reset sequences.
module tb_multicycle_control;
   import risc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0;
   logic       imem_ack = 1'b0;
   logic       dmem_ack = 1'b0;
   logic       imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write;
   logic [1:0] reg_write;
   logic       mem_to_reg;
   logic [2:0] alu_op;
   logic       alu_src;
   logic [1:0] branch;
   logic       trap;
   logic [2:0] state_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_control #(
      .OPCODE_W (6),
      .ALU_OP_W (3),
      .WAIT_MAX (15)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .imem_ack   (imem_ack),
      .dmem_ack   (dmem_ack),
      .imem_req   (imem_req),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .dmem_req   (dmem_req),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .alu_op     (alu_op),
      .alu_src    (alu_src),
      .branch     (branch),
      .trap       (trap),
      .state_o    (state_o)
   );

   // Observed vector: {state, imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write, reg_write, mem_to_reg, alu_op, alu_src, branch, trap}
   logic [18:0] act;
   assign act = {state_o, imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write,
                 reg_write, mem_to_reg, alu_op, alu_src, branch, trap};

   typedef struct {
      string       nm;
      logic [5:0]  op;
      logic        ia;
      logic        da;
      logic [18:0] ex;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [18:0] o(input logic [2:0] st, input logic ireq, input logic irw,
                                     input logic pcw, input logic dreq, input logic mrd,
                                     input logic mwr, input logic [1:0] rw, input logic m2r,
                                     input logic [2:0] aop, input logic asrc,
                                     input logic [1:0] br, input logic tr);
      return {st, ireq, irw, pcw, dreq, mrd, mwr, rw, m2r, aop, asrc, br, tr};
   endfunction

   function automatic logic [18:0] f_ex(input logic irw);
      return o(FETCH, 1'b1, irw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
   endfunction

   function automatic logic [18:0] d_ex();
      return o(DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
   endfunction

   function automatic logic [18:0] trap_ex();
      return o(TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1);
   endfunction

   function automatic logic [18:0] exec_ex(input logic [2:0] aop, input logic asrc,
                                           input logic [1:0] br, input logic [1:0] rw,
                                           input logic pcw);
      return o(EXEC, 1'b0, 1'b0, pcw, 1'b0, 1'b0, 1'b0, rw, 1'b0, aop, asrc, br, 1'b0);
   endfunction

   function automatic logic [18:0] mem_ex(input logic rd, input logic wr, input logic pcw);
      return o(MEM, 1'b0, 1'b0, pcw, 1'b1, rd, wr, 2'b00, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
   endfunction

   function automatic logic [18:0] wb_ex(input logic [1:0] rw, input logic m2r);
      return o(WB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rw, m2r, 3'b000, 1'b0, 2'b00, 1'b0);
   endfunction

   task automatic add(input string nm, input logic [5:0] op, input logic ia, input logic da,
                      input logic [18:0] ex);
      vec_t v;
      v.nm = nm;
      v.op = op;
      v.ia = ia;
      v.da = da;
      v.ex = ex;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [18:0] got, input logic [18:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, got, want);
      end
   endtask

   // Drive one cycle's inputs after the falling edge and settle before sampling.
   task automatic cyc(input logic ia, input logic da, input logic [5:0] op);
      @(negedge clk);
      imem_ack = ia;
      dmem_ack = da;
      opcode   = op;
      #1;
   endtask

   // Asserts reset, checks the idle outputs, releases away from any clock edge.
   task automatic do_reset();
      rst      = 1'b1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      #1;
      check("reset_outputs", act, 19'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      add("addi_fetch",  6'd0, 1'b1, 1'b0, f_ex(1'b1));
      add("addi_decode", 6'd0, 1'b1, 1'b1, d_ex());
      add("addi_exec",   6'h3F, 1'b0, 1'b1, exec_ex(3'b001, 1'b1, 2'b00, 2'b00, 1'b0));
      add("addi_wb",     6'd0, 1'b0, 1'b0, wb_ex(2'b10, 1'b0));
      add("lw_fetch",    6'd5, 1'b1, 1'b0, f_ex(1'b1));
      add("lw_decode",   6'd5, 1'b0, 1'b0, d_ex());
      add("lw_exec",     6'd5, 1'b0, 1'b0, exec_ex(3'b100, 1'b0, 2'b00, 2'b00, 1'b0));
      add("lw_mem1",     6'd5, 1'b1, 1'b0, mem_ex(1'b1, 1'b0, 1'b0));
      add("lw_mem2",     6'd5, 1'b0, 1'b0, mem_ex(1'b1, 1'b0, 1'b0));
      add("lw_mem3",     6'd5, 1'b0, 1'b1, mem_ex(1'b1, 1'b0, 1'b0));
      add("lw_wb",       6'd5, 1'b0, 1'b0, wb_ex(2'b11, 1'b1));
      add("jal_fetch",   6'd9, 1'b1, 1'b0, f_ex(1'b1));
      add("jal_decode",  6'd9, 1'b0, 1'b0, d_ex());
      add("jal_exec",    6'd9, 1'b0, 1'b0, exec_ex(3'b000, 1'b1, 2'b11, 2'b01, 1'b1));
      add("sw_fetch_w",  6'd6, 1'b0, 1'b0, f_ex(1'b0));
      add("sw_fetch",    6'd6, 1'b1, 1'b0, f_ex(1'b1));
      add("sw_decode",   6'd6, 1'b0, 1'b0, d_ex());
      add("sw_exec",     6'd6, 1'b0, 1'b0, exec_ex(3'b101, 1'b0, 2'b00, 2'b00, 1'b0));
      add("sw_mem",      6'd6, 1'b0, 1'b1, mem_ex(1'b0, 1'b1, 1'b1));
      add("beq_fetch",   6'd3, 1'b1, 1'b0, f_ex(1'b1));
      add("beq_decode",  6'd3, 1'b0, 1'b0, d_ex());
      add("beq_exec",    6'd3, 1'b0, 1'b0, exec_ex(3'b000, 1'b1, 2'b01, 2'b00, 1'b1));
      add("bne_fetch",   6'd4, 1'b1, 1'b0, f_ex(1'b1));
      add("bne_decode",  6'd4, 1'b0, 1'b0, d_ex());
      add("bne_exec",    6'd4, 1'b0, 1'b0, exec_ex(3'b000, 1'b1, 2'b10, 2'b00, 1'b1));
      add("add_fetch",   6'd7, 1'b1, 1'b0, f_ex(1'b1));
      add("add_decode",  6'd7, 1'b0, 1'b0, d_ex());
      add("add_exec",    6'd7, 1'b0, 1'b0, exec_ex(3'b110, 1'b0, 2'b00, 2'b00, 1'b0));
      add("add_wb",      6'd7, 1'b0, 1'b0, wb_ex(2'b10, 1'b0));
      add("sub_fetch",   6'd8, 1'b1, 1'b0, f_ex(1'b1));
      add("sub_decode",  6'd8, 1'b0, 1'b0, d_ex());
      add("sub_exec",    6'd8, 1'b0, 1'b0, exec_ex(3'b111, 1'b0, 2'b00, 2'b00, 1'b0));
      add("sub_wb",      6'd8, 1'b0, 1'b0, wb_ex(2'b10, 1'b0));
      add("andi_fetch",  6'd1, 1'b1, 1'b0, f_ex(1'b1));
      add("andi_decode", 6'd1, 1'b0, 1'b0, d_ex());
      add("andi_exec",   6'd1, 1'b0, 1'b0, exec_ex(3'b010, 1'b1, 2'b00, 2'b00, 1'b0));
      add("andi_wb",     6'd1, 1'b0, 1'b0, wb_ex(2'b10, 1'b0));
      add("ori_fetch",   6'd2, 1'b1, 1'b0, f_ex(1'b1));
      add("ori_decode",  6'd2, 1'b0, 1'b0, d_ex());
      add("ori_exec",    6'd2, 1'b0, 1'b0, exec_ex(3'b011, 1'b1, 2'b00, 2'b00, 1'b0));
      add("ori_wb",      6'd2, 1'b0, 1'b0, wb_ex(2'b10, 1'b0));
      add("idle_fetch",  6'd0, 1'b0, 1'b0, f_ex(1'b0));

      do_reset();
      foreach (vecs[i]) begin
         cyc(vecs[i].ia, vecs[i].da, vecs[i].op);
         check(vecs[i].nm, act, vecs[i].ex);
      end

      // Lowest illegal opcode traps straight after DECODE.
      do_reset();
      cyc(1'b1, 1'b0, 6'd10);
      check("ill10_fetch", act, f_ex(1'b1));
      cyc(1'b0, 1'b0, 6'd10);
      check("ill10_decode", act, d_ex());
      cyc(1'b0, 1'b0, 6'd0);
      check("ill10_trap", act, trap_ex());

      // All-ones opcode: trap is sticky for 100 cycles whatever the inputs do.
      do_reset();
      cyc(1'b1, 1'b0, 6'd0);
      check("ill3f_fetch", act, f_ex(1'b1));
      cyc(1'b0, 1'b0, 6'h3F);
      check("ill3f_decode", act, d_ex());
      for (int i = 0; i < 100; i++) begin
         cyc(1'($urandom), 1'($urandom), 6'($urandom));
         check("trap_hold", act, trap_ex());
      end
      do_reset();
      cyc(1'b0, 1'b0, 6'd0);
      check("trap_cleared", act, f_ex(1'b0));

      // Instruction fetch never acked: 15 request cycles, then TRAP.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         cyc(1'b0, 1'b0, 6'd0);
         check("imem_wait", act, f_ex(1'b0));
      end
      cyc(1'b1, 1'b1, 6'd0);
      check("imem_timeout", act, trap_ex());

      // Ack on the 15th request cycle still wins.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         cyc(1'b0, 1'b0, 6'd0);
         check("imem_wait_late", act, f_ex(1'b0));
      end
      cyc(1'b1, 1'b0, 6'd0);
      check("imem_ack_last", act, f_ex(1'b1));
      cyc(1'b0, 1'b0, 6'd0);
      check("decode_after_late_ack", act, d_ex());

      // Load whose data memory never acks.
      do_reset();
      cyc(1'b1, 1'b0, 6'd5);
      check("lwto_fetch", act, f_ex(1'b1));
      cyc(1'b0, 1'b0, 6'd5);
      check("lwto_decode", act, d_ex());
      cyc(1'b0, 1'b0, 6'd5);
      check("lwto_exec", act, exec_ex(3'b100, 1'b0, 2'b00, 2'b00, 1'b0));
      for (int i = 0; i < 15; i++) begin
         cyc(1'b0, 1'b0, 6'd5);
         check("lwto_mem", act, mem_ex(1'b1, 1'b0, 1'b0));
      end
      cyc(1'b0, 1'b1, 6'd5);
      check("dmem_timeout", act, trap_ex());

      // Reset arriving mid-store clears outputs at once and restarts from FETCH.
      do_reset();
      cyc(1'b1, 1'b0, 6'd6);
      check("swrst_fetch", act, f_ex(1'b1));
      cyc(1'b0, 1'b0, 6'd6);
      check("swrst_decode", act, d_ex());
      cyc(1'b0, 1'b0, 6'd6);
      check("swrst_exec", act, exec_ex(3'b101, 1'b0, 2'b00, 2'b00, 1'b0));
      cyc(1'b0, 1'b0, 6'd6);
      check("swrst_mem", act, mem_ex(1'b0, 1'b1, 1'b0));
      #1;
      rst = 1'b1;
      #1;
      check("swrst_async", act, 19'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      cyc(1'b0, 1'b1, 6'd6);
      check("swrst_restart", act, f_ex(1'b0));
      cyc(1'b1, 1'b1, 6'd6);
      check("swrst_refetch", act, f_ex(1'b1));
      cyc(1'b0, 1'b1, 6'd6);
      check("swrst_redecode", act, d_ex());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
